gcd_axil_slave: RTL

- AXI4-Lite responder that exposes an iterative 32-bit GCD engine through four memory-mapped registers; it is the slave end of the bus the AXI VIP master drives in our block-design benches.
- Software writes operands A and B, then pulses START; the engine runs subtractive Euclid, one step per clock.
- Software polls STATUS or waits on IRQ, then reads RESULT.

---
 rtl/gcd_axil_slave_if.sv | 55 +++++
 rtl/gcd_axil_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_axil_slave_if.sv
// AXI4-Lite bus bundle for the GCD register block.
// Ports (signals): AW channel (AWADDR, AWPROT, AWVALID/AWREADY),
// W channel (WDATA, WSTRB, WVALID/WREADY), B channel (BRESP, BVALID/BREADY),
// AR channel (ARADDR, ARPROT, ARVALID/ARREADY), R channel (RDATA, RRESP, RVALID/RREADY).
// Modports: master drives address/data/ready-for-response, slave answers.
interface gcd_axil_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/gcd_axil_slave.sv
// AXI4-Lite slave wrapping an iterative subtractive-Euclid GCD engine.
// Ports:
//   ACLK    - single clock
//   ARESET  - synchronous active-high reset
//   s_axi   - AXI4-Lite slave bundle (gcd_axil_slave_if.slave)
//   IRQ     - level interrupt, STATUS.DONE & CTRL.IE
// Register map (addr[3:2]): 0 OPA, 1 OPB, 2 CTRL/STATUS, 3 RESULT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | engine stopped, waiting for START write
// ST_RUN  | one subtract step per clock until a==b or an operand is 0
module gcd_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    gcd_axil_slave_if.slave   s_axi,
    output logic              IRQ
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic        aw_cap_q, aw_cap_d;
    logic        w_cap_q, w_cap_d;
    logic [1:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic [15:0] iter_q, iter_d;
    logic        done_q, done_d;
    logic        ie_q, ie_d;

    logic        awready, wready, arready;
    logic        aw_hs, w_hs, ar_hs;
    logic        do_write, ctrl_wr, start;
    logic [31:0] status;
    logic [31:0] rd_mux;

    logic        unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                         C_S_AXI_DATA_WIDTH[0], C_S_AXI_ADDR_WIDTH[0]};

    // Ready only depends on flops, so it never combinationally loops on VALID.
    assign awready = !aw_cap_q && !bvalid_q;
    assign wready  = !w_cap_q && !bvalid_q;
    assign arready = !rvalid_q;
    assign aw_hs   = s_axi.S_AXI_AWVALID && awready;
    assign w_hs    = s_axi.S_AXI_WVALID && wready;
    assign ar_hs   = s_axi.S_AXI_ARVALID && arready;

    // The captured write is applied one cycle after both halves are held.
    assign do_write = aw_cap_q && w_cap_q;
    assign ctrl_wr  = do_write && (waddr_q == 2'd2) && wstrb_q[0];
    assign start    = ctrl_wr && wdata_q[0] && (state_q == ST_IDLE);

    assign status = {iter_q, 12'h000, ie_q, done_q, (state_q == ST_RUN), 1'b0};

    always_comb begin
        rd_mux = 32'h0;
        case (s_axi.S_AXI_ARADDR[3:2])
            2'd0:    rd_mux = opa_q;
            2'd1:    rd_mux = opb_q;
            2'd2:    rd_mux = status;
            default: rd_mux = result_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        aw_cap_d = aw_cap_q;
        w_cap_d  = w_cap_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        iter_d   = iter_q;
        done_d   = done_q;
        ie_d     = ie_q;

        if (aw_hs) begin
            aw_cap_d = 1'b1;
            waddr_d  = s_axi.S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_cap_d = 1'b1;
            wdata_d = s_axi.S_AXI_WDATA;
            wstrb_d = s_axi.S_AXI_WSTRB;
        end
        if (do_write) begin
            aw_cap_d = 1'b0;
            w_cap_d  = 1'b0;
            bvalid_d = 1'b1;
        end
        if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Read samples register values before this edge's write lands.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        if (do_write && waddr_q == 2'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) opa_d[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        if (do_write && waddr_q == 2'd1) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) opb_d[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        if (ctrl_wr) begin
            ie_d = wdata_q[3];
            if (wdata_q[2]) done_d = 1'b0;
        end

        // FSM assignments come after the W1C so a simultaneous set wins.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = opa_q;
                    b_d     = opb_q;
                    iter_d  = 16'h0;
                    done_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (a_q == b_q || a_q == 32'h0 || b_q == 32'h0) begin
                    result_d = (a_q == 32'h0) ? b_q : a_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    if (a_q > b_q) a_d = a_q - b_q;
                    else           b_d = b_q - a_q;
                    if (iter_q != 16'hFFFF) iter_d = iter_q + 16'h1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            aw_cap_q <= 1'b0;
            w_cap_q  <= 1'b0;
            waddr_q  <= 2'd0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            opa_q    <= 32'h0;
            opb_q    <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            result_q <= 32'h0;
            iter_q   <= 16'h0;
            done_q   <= 1'b0;
            ie_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_cap_q <= aw_cap_d;
            w_cap_q  <= w_cap_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            iter_q   <= iter_d;
            done_q   <= done_d;
            ie_q     <= ie_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign IRQ                 = done_q && ie_q;

endmodule
